// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-driven W-bit RAM behind an SPI-style byte stream, with sticky error flag.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 err
);
  localparam int W = ADDR_SIZE;
  localparam logic [W:0] DEPTH = (W+1)'(MEM_DEPTH);
  typedef enum logic [1:0] {SET_WR = 2'b00, WRITE = 2'b01, SET_RD = 2'b10, READ = 2'b11} cmd_t;
  cmd_t cmd;
  logic [W-1:0] pay, wr_addr, rd_addr;
  logic [W-1:0] mem [MEM_DEPTH];
  logic rd_armed, wr_ok, rd_ok, rd_go, we;
  assign cmd = cmd_t'(din[W+1:W]);
  assign pay = din[W-1:0];
  assign wr_ok = {1'b0, wr_addr} < DEPTH;
  assign rd_ok = {1'b0, rd_addr} < DEPTH;
  assign rd_go = rx_valid && cmd == READ && rd_armed && !tx_valid;
  assign we = rx_valid && cmd == WRITE && wr_ok;
  // Wrap is modulo MEM_DEPTH so incrementing never walks into the unmapped range.
  function automatic logic [W-1:0] inc(input logic [W-1:0] a);
    return ({1'b0, a} == DEPTH - 1'b1) ? '0 : a + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= pay;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout <= '0;
      tx_valid <= 1'b0;
      err <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      rd_armed <= 1'b0;
    end else begin
      tx_valid <= rd_go;
      if (rx_valid)
        case (cmd)
          SET_WR: wr_addr <= pay;
          WRITE: begin
            err <= err | ~wr_ok;
            if (AUTO_INC) wr_addr <= inc(wr_addr);
          end
          SET_RD: begin
            rd_addr <= pay;
            rd_armed <= 1'b1;
          end
          READ:
            if (rd_go) begin
              dout <= rd_ok ? mem[rd_addr] : '0;
              err <= err | ~rd_ok;
              if (AUTO_INC) rd_addr <= inc(rd_addr);
              else rd_armed <= 1'b0;
            end else err <= 1'b1;
        endcase
    end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed checks of three spi_ram_ctrl configurations with a read-data scoreboard.
module tb_spi_ram_ctrl;
  logic clk, rst_n;
  logic [2:0][9:0] din;
  logic [2:0][7:0] dout;
  logic [2:0] rxv, txv, err;
  logic [7:0] q[$];
  int vectors, errors;

  spi_ram_ctrl u0 (.clk(clk), .rst_n(rst_n), .din(din[0]), .rx_valid(rxv[0]),
                   .dout(dout[0]), .tx_valid(txv[0]), .err(err[0]));
  spi_ram_ctrl #(.AUTO_INC(1)) u1 (.clk(clk), .rst_n(rst_n), .din(din[1]), .rx_valid(rxv[1]),
                   .dout(dout[1]), .tx_valid(txv[1]), .err(err[1]));
  spi_ram_ctrl #(.MEM_DEPTH(200)) u2 (.clk(clk), .rst_n(rst_n), .din(din[2]), .rx_valid(rxv[2]),
                   .dout(dout[2]), .tx_valid(txv[2]), .err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input int u);
    logic [7:0] e;
    chk("tx_valid", {31'b0, txv[u]}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("dout", {24'b0, dout[u]}, {24'b0, e});
    end
  endtask

  // Drive one command for a cycle; exp_rd marks a read expected to return data.
  task automatic send(input int u, input logic [1:0] c, input logic [7:0] p, input bit exp_rd, input logic [7:0] d);
    din[u] = {c, p};
    rxv[u] = 1'b1;
    if (exp_rd) q.push_back(d);
    @(posedge clk);
    #1;
    rxv[u] = 1'b0;
    check_tx(u);
  endtask

  task automatic idle(input int u);
    @(posedge clk);
    #1;
    check_tx(u);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_dout", {24'b0, dout[i]}, 32'h0);
      chk("rst_tx", {31'b0, txv[i]}, 32'h0);
      chk("rst_err", {31'b0, err[i]}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    din = '0;
    rxv = '0;
    pulse_reset();
    // Basic write then read back
    send(0, 2'b00, 8'h12, 0, 8'h00);
    send(0, 2'b01, 8'hAB, 0, 8'h00);
    send(0, 2'b10, 8'h12, 0, 8'h00);
    send(0, 2'b11, 8'h00, 1, 8'hAB);
    idle(0);
    chk("err_clean", {31'b0, err[0]}, 32'h0);
    // Write immediately followed by a read of the same address
    send(0, 2'b10, 8'h30, 0, 8'h00);
    send(0, 2'b00, 8'h30, 0, 8'h00);
    send(0, 2'b01, 8'h5C, 0, 8'h00);
    send(0, 2'b11, 8'h77, 1, 8'h5C);
    idle(0);
    idle(0);
    chk("dout_hold", {24'b0, dout[0]}, 32'h5C);
    chk("err_raw", {31'b0, err[0]}, 32'h0);
    // Back-to-back reads: one pulse, second dropped with err
    send(0, 2'b10, 8'h12, 0, 8'h00);
    send(0, 2'b11, 8'h00, 1, 8'hAB);
    send(0, 2'b11, 8'h00, 0, 8'h00);
    chk("b2b_err", {31'b0, err[0]}, 32'h1);
    chk("b2b_dout", {24'b0, dout[0]}, 32'hAB);
    send(0, 2'b00, 8'h01, 0, 8'h00);
    chk("err_sticky", {31'b0, err[0]}, 32'h1);
    // Unarmed read after reset
    pulse_reset();
    send(0, 2'b11, 8'h00, 0, 8'h00);
    chk("unarmed_dout", {24'b0, dout[0]}, 32'h0);
    chk("unarmed_err", {31'b0, err[0]}, 32'h1);
    // Reset right after an accepted read; memory survives
    pulse_reset();
    send(0, 2'b10, 8'h12, 0, 8'h00);
    send(0, 2'b11, 8'h00, 1, 8'hAB);
    rst_n = 1'b0;
    #1;
    chk("async_tx", {31'b0, txv[0]}, 32'h0);
    chk("async_dout", {24'b0, dout[0]}, 32'h0);
    chk("async_err", {31'b0, err[0]}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0);
    idle(0);
    send(0, 2'b10, 8'h12, 0, 8'h00);
    send(0, 2'b11, 8'h00, 1, 8'hAB);
    idle(0);
    chk("rearm_err", {31'b0, err[0]}, 32'h0);
    // Auto-increment with wrap
    send(1, 2'b00, 8'hFF, 0, 8'h00);
    send(1, 2'b01, 8'h11, 0, 8'h00);
    send(1, 2'b01, 8'h22, 0, 8'h00);
    send(1, 2'b10, 8'hFF, 0, 8'h00);
    send(1, 2'b11, 8'h00, 1, 8'h11);
    idle(1);
    send(1, 2'b11, 8'h00, 1, 8'h22);
    idle(1);
    chk("inc_err", {31'b0, err[1]}, 32'h0);
    // Reduced depth: out-of-range write and read
    send(2, 2'b00, 8'h05, 0, 8'h00);
    send(2, 2'b01, 8'h77, 0, 8'h00);
    send(2, 2'b10, 8'h05, 0, 8'h00);
    send(2, 2'b11, 8'h00, 1, 8'h77);
    chk("depth_ok_err", {31'b0, err[2]}, 32'h0);
    send(2, 2'b00, 8'hC8, 0, 8'h00);
    send(2, 2'b01, 8'h55, 0, 8'h00);
    chk("oor_wr_err", {31'b0, err[2]}, 32'h1);
    send(2, 2'b10, 8'hC8, 0, 8'h00);
    send(2, 2'b11, 8'h00, 1, 8'h00);
    idle(2);
    chk("oor_rd_err", {31'b0, err[2]}, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of memory words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, meaning the address width and the data word width (W).
REQ-003 The block SHALL have parameter AUTO_INC, default 0, meaning that a value of 1 enables address post-increment after each data access.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port din, input, W+2 bits: din[W+1:W] is the command and din[W-1:0] is the payload.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: din is valid in this cycle.
REQ-008 The block SHALL have port dout, output, W bits: read data.
REQ-009 The block SHALL have port tx_valid, output, 1 bit: dout is valid (one-cycle pulse).
REQ-010 The block SHALL have port err, output, 1 bit: sticky protocol/range error flag.

Function
REQ-011 Commands SHALL be decoded only at a rising edge with rx_valid=1; with rx_valid=0, no state other than tx_valid SHALL change.
REQ-012 Command 00 SHALL load wr_addr with the payload.
REQ-013 Command 01 SHALL write the payload to mem[wr_addr]; if AUTO_INC=1, wr_addr SHALL then advance by 1 and wrap from MEM_DEPTH-1 to 0.
REQ-014 Command 10 SHALL load rd_addr with the payload and set the internal flag rd_armed=1.
REQ-015 Command 11 with rd_armed=1 and tx_valid=0 SHALL drive dout=mem[rd_addr] and tx_valid=1 in the next cycle (latency 1); if AUTO_INC=1, rd_addr SHALL advance with the same wrap; if AUTO_INC=0, rd_armed SHALL clear.
REQ-016 The payload of command 11 SHALL be ignored.
REQ-017 tx_valid SHALL be high for exactly one cycle per accepted read and SHALL return to 0 in the following cycle.
REQ-018 Command 11 while rd_armed=0 SHALL produce no tx_valid, SHALL leave dout unchanged, and SHALL set err.
REQ-019 Command 11 arriving while tx_valid=1 (back-to-back read) SHALL be dropped and SHALL set err; the bench sees a tx_valid pattern of 1,0, never 1,1.
REQ-020 Commands 00, 01 and 10 SHALL never assert tx_valid in the following cycle.
REQ-021 When MEM_DEPTH < 2^W, a write to an address >= MEM_DEPTH SHALL be discarded and SHALL set err.
REQ-022 When MEM_DEPTH < 2^W, a read from an address >= MEM_DEPTH SHALL return dout=0 with tx_valid=1 and SHALL set err.
REQ-023 Under AUTO_INC=1, address wrap SHALL be modulo MEM_DEPTH, so an out-of-range address is never reached by increment.
REQ-024 dout SHALL hold its last value between reads.
REQ-025 err SHALL be sticky and SHALL be cleared only by reset.
REQ-026 A write and a read to the same address in consecutive cycles SHALL return the newly written data.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0 and rd_armed=0.
REQ-028 Memory contents SHALL NOT be reset; reads of never-written locations are undefined, and benches SHALL write before reading.
REQ-029 Reset asserted in the cycle after an accepted command 11 SHALL clear tx_valid at once; no pulse is delivered after release.
REQ-030 The first command SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-031 Default parameters; send 00/0x12, 01/0xAB, 10/0x12, 11/0x00 -> dout=0xAB with tx_valid=1 one cycle after the 11 command, tx_valid=0 the next cycle, err=0.
REQ-032 After reset, send command 11 with no prior 10 -> tx_valid stays 0, dout=0, err=1.
REQ-033 Two command-11 beats in consecutive cycles after an arming 10 -> a single tx_valid pulse and err=1.
REQ-034 AUTO_INC=1, MEM_DEPTH=256; send 00/0xFF, then 01/0x11 and 01/0x22; send 10/0xFF, then 11 and 11 in non-consecutive cycles -> dout reads 0x11 then 0x22 (address wrapped to 0), err=0.
REQ-035 MEM_DEPTH=200; send 00/0xC8, 01/0x55 -> err=1; send 10/0xC8, 11 -> dout=0, tx_valid pulse.
REQ-036 Assert rst_n=0 mid-stream one cycle after a command 11 -> tx_valid, dout and err all 0 asynchronously; a previously written location still reads back its data after the re-arming sequence.
